// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared comparator op codes, funct3 constants and resolver states
package branch_pkg;

    // Comparator op codes, shared with the ALU comparator
    localparam logic [4:0] CMP_BEQ  = 5'd0;
    localparam logic [4:0] CMP_BNE  = 5'd1;
    localparam logic [4:0] CMP_BLT  = 5'd2;
    localparam logic [4:0] CMP_BGE  = 5'd3;
    localparam logic [4:0] CMP_BLTU = 5'd4;
    localparam logic [4:0] CMP_BGEU = 5'd5;

    // RISC-V conditional branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        EVAL = 2'd2,
        HOLD = 2'd3
    } br_state_e;

endpackage

// File: rtl/br_op_decode.sv
// rtl/br_op_decode.sv - funct3 to comparator op code decode
module br_op_decode
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    output logic [4:0] op,
    output logic       illegal
);

    // Map branch funct3 onto comparator op; 010/011 have no branch meaning
    always_comb begin
        op      = CMP_BEQ;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  op = CMP_BEQ;
            F3_BNE:  op = CMP_BNE;
            F3_BLT:  op = CMP_BLT;
            F3_BGE:  op = CMP_BGE;
            F3_BLTU: op = CMP_BLTU;
            F3_BGEU: op = CMP_BGEU;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - conditional branch sequencer in front of the ALU comparator
module branch_resolver
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            soc_clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] br_rs1,
    input  logic [XLEN-1:0] br_rs2,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    output logic            dat_ready,
    output logic [XLEN-1:0] ALU_dat1,
    output logic [XLEN-1:0] ALU_dat2,
    output logic [4:0]      Instruction_to_ALU,
    input  logic            Comparator_con_met,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_taken,
    output logic [XLEN-1:0] res_next_pc,
    output logic            res_misaligned,
    output logic            res_illegal
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    br_state_e       state;
    logic [4:0]      dec_op;
    logic            dec_illegal;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] fall_q;

    br_op_decode u_op_decode (
        .funct3  (br_funct3),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    // Ready depends only on the state register plus the flush/reset gates
    assign br_ready = (state == IDLE) && !flush && !reset;

    // Resolver FSM with registered comparator strobe and result outputs
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state              <= IDLE;
            dat_ready          <= 1'b0;
            ALU_dat1           <= '0;
            ALU_dat2           <= '0;
            Instruction_to_ALU <= CMP_BEQ;
            target_q           <= '0;
            fall_q             <= '0;
            res_valid          <= 1'b0;
            res_taken          <= 1'b0;
            res_next_pc        <= '0;
            res_misaligned     <= 1'b0;
            res_illegal        <= 1'b0;
        end else if (flush) begin
            // Abort: drop any in-flight branch, operands are left as captured
            state          <= IDLE;
            dat_ready      <= 1'b0;
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_next_pc    <= '0;
            res_misaligned <= 1'b0;
            res_illegal    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (br_valid && br_ready) begin
                        ALU_dat1           <= br_rs1;
                        ALU_dat2           <= br_rs2;
                        Instruction_to_ALU <= dec_op;
                        target_q           <= br_pc + br_imm;
                        fall_q             <= br_pc + PC_STEP;
                        if (dec_illegal) begin
                            // Illegal funct3 never reaches the comparator
                            state          <= HOLD;
                            res_valid      <= 1'b1;
                            res_illegal    <= 1'b1;
                            res_taken      <= 1'b0;
                            res_misaligned <= 1'b0;
                            res_next_pc    <= br_pc + PC_STEP;
                        end else begin
                            state     <= CMP;
                            dat_ready <= 1'b1;
                        end
                    end
                end
                CMP: begin
                    dat_ready <= 1'b0;
                    state     <= EVAL;
                end
                EVAL: begin
                    res_valid      <= 1'b1;
                    res_illegal    <= 1'b0;
                    res_taken      <= Comparator_con_met;
                    res_next_pc    <= Comparator_con_met ? target_q : fall_q;
                    res_misaligned <= Comparator_con_met && (target_q[1:0] != 2'b00);
                    state          <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid      <= 1'b0;
                        res_taken      <= 1'b0;
                        res_next_pc    <= '0;
                        res_misaligned <= 1'b0;
                        res_illegal    <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed scoreboard bench for branch_resolver
module tb_branch_resolver;

    logic        soc_clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [2:0]  br_funct3 = 3'b000;
    logic [31:0] br_rs1 = '0;
    logic [31:0] br_rs2 = '0;
    logic [31:0] br_pc = '0;
    logic [31:0] br_imm = '0;
    logic        dat_ready;
    logic [31:0] ALU_dat1;
    logic [31:0] ALU_dat2;
    logic [4:0]  Instruction_to_ALU;
    logic        Comparator_con_met;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_taken;
    logic [31:0] res_next_pc;
    logic        res_misaligned;
    logic        res_illegal;

    typedef struct {
        logic        taken;
        logic [31:0] npc;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    branch_resolver #(.XLEN(32)) dut (
        .soc_clk            (soc_clk),
        .reset              (reset),
        .flush              (flush),
        .br_valid           (br_valid),
        .br_ready           (br_ready),
        .br_funct3          (br_funct3),
        .br_rs1             (br_rs1),
        .br_rs2             (br_rs2),
        .br_pc              (br_pc),
        .br_imm             (br_imm),
        .dat_ready          (dat_ready),
        .ALU_dat1           (ALU_dat1),
        .ALU_dat2           (ALU_dat2),
        .Instruction_to_ALU (Instruction_to_ALU),
        .Comparator_con_met (Comparator_con_met),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_taken          (res_taken),
        .res_next_pc        (res_next_pc),
        .res_misaligned     (res_misaligned),
        .res_illegal        (res_illegal)
    );

    always #5 soc_clk = ~soc_clk;

    // Registered comparator: result appears the cycle after the strobe, 0 otherwise
    always_ff @(posedge soc_clk) begin
        if (reset || !dat_ready) begin
            Comparator_con_met <= 1'b0;
        end else begin
            case (Instruction_to_ALU)
                5'd0:    Comparator_con_met <= (ALU_dat1 == ALU_dat2);
                5'd1:    Comparator_con_met <= (ALU_dat1 != ALU_dat2);
                5'd2:    Comparator_con_met <= ($signed(ALU_dat1) < $signed(ALU_dat2));
                5'd3:    Comparator_con_met <= ($signed(ALU_dat1) >= $signed(ALU_dat2));
                5'd4:    Comparator_con_met <= (ALU_dat1 < ALU_dat2);
                5'd5:    Comparator_con_met <= (ALU_dat1 >= ALU_dat2);
                default: Comparator_con_met <= 1'b0;
            endcase
        end
    end

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_op(input logic [2:0] f3);
        case (f3)
            3'b001:  return 32'd1;
            3'b100:  return 32'd2;
            3'b101:  return 32'd3;
            3'b110:  return 32'd4;
            3'b111:  return 32'd5;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] pc, input logic [31:0] imm);
        @(posedge soc_clk);
        #1;
        br_valid  = 1'b1;
        br_funct3 = f3;
        br_rs1    = rs1;
        br_rs2    = rs2;
        br_pc     = pc;
        br_imm    = imm;
        @(negedge soc_clk);
        chk("br_ready_at_accept", 32'(br_ready), 32'd1);
        @(posedge soc_clk);
        #1;
        br_valid = 1'b0;
    endtask

    task automatic do_branch(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] pc, input logic [31:0] imm, input int hold);
        exp_t        e;
        exp_t        got;
        logic [31:0] tgt;
        int          first_valid;
        int          dr_cnt;
        int          dr_cyc;
        first_valid = -1;
        dr_cnt      = 0;
        dr_cyc      = -1;
        tgt         = pc + imm;
        e.ill       = (f3 == 3'b010) || (f3 == 3'b011);
        e.taken     = e.ill ? 1'b0 : ref_taken(f3, rs1, rs2);
        e.npc       = e.taken ? tgt : pc + 32'd4;
        e.mis       = e.taken && (tgt[1:0] != 2'b00);
        sb.push_back(e);
        accept(f3, rs1, rs2, pc, imm);
        for (int c = 1; c <= 8; c++) begin
            @(negedge soc_clk);
            if (dat_ready) begin
                dr_cnt++;
                dr_cyc = c;
            end
            if (c == 1 && !e.ill) begin
                chk("op_code", 32'(Instruction_to_ALU), ref_op(f3));
                chk("alu_dat1", ALU_dat1, rs1);
                chk("alu_dat2", ALU_dat2, rs2);
            end
            if (res_valid) begin
                first_valid = c;
                break;
            end
        end
        chk("res_valid_cycle", 32'(first_valid), e.ill ? 32'd1 : 32'd3);
        chk("dat_ready_count", 32'(dr_cnt), e.ill ? 32'd0 : 32'd1);
        if (!e.ill) chk("dat_ready_cycle", 32'(dr_cyc), 32'd1);
        got = sb.pop_front();
        chk("res_taken", 32'(res_taken), 32'(got.taken));
        chk("res_next_pc", res_next_pc, got.npc);
        chk("res_misaligned", 32'(res_misaligned), 32'(got.mis));
        chk("res_illegal", 32'(res_illegal), 32'(got.ill));
        for (int h = 0; h < hold; h++) begin
            @(negedge soc_clk);
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_next_pc", res_next_pc, got.npc);
            chk("hold_misaligned", 32'(res_misaligned), 32'(got.mis));
            chk("hold_br_ready", 32'(br_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge soc_clk);
        #1;
        res_ready = 1'b0;
        @(negedge soc_clk);
        chk("after_hs_valid", 32'(res_valid), 32'd0);
        chk("after_hs_br_ready", 32'(br_ready), 32'd1);
    endtask

    initial begin
        int seen;

        // Reset state, sampled while reset is still asserted
        repeat (2) @(posedge soc_clk);
        @(negedge soc_clk);
        chk("rst_br_ready", 32'(br_ready), 32'd0);
        chk("rst_dat_ready", 32'(dat_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_alu_dat1", ALU_dat1, 32'd0);
        chk("rst_op", 32'(Instruction_to_ALU), 32'd0);
        chk("rst_next_pc", res_next_pc, 32'd0);
        @(posedge soc_clk);
        #1;
        reset = 1'b0;
        @(negedge soc_clk);
        chk("idle_br_ready", 32'(br_ready), 32'd1);

        // Directed branches
        do_branch(3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20, 0);
        do_branch(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 0);
        do_branch(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 0);
        do_branch(3'b111, 32'h5, 32'h5, 32'hFFFF_FFF8, 32'h10, 0);
        do_branch(3'b111, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h10, 0);
        do_branch(3'b101, 32'h7, 32'hFFFF_FFFD, 32'h400, 32'hFFFF_FFF0, 0);
        do_branch(3'b010, 32'h1, 32'h1, 32'h500, 32'h8, 0);
        do_branch(3'b011, 32'h2, 32'h3, 32'h504, 32'h8, 1);

        // Flush while in CMP: no result, ready again in the following cycle
        accept(3'b000, 32'h1, 32'h1, 32'h500, 32'h8);
        flush = 1'b1;
        @(posedge soc_clk);
        #1;
        flush = 1'b0;
        @(negedge soc_clk);
        chk("flush_br_ready", 32'(br_ready), 32'd1);
        chk("flush_dat_ready", 32'(dat_ready), 32'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge soc_clk);
            if (res_valid) seen++;
        end
        chk("flush_no_result", 32'(seen), 32'd0);
        do_branch(3'b001, 32'h3, 32'h4, 32'h600, 32'h100, 0);

        // Reset while in EVAL
        accept(3'b001, 32'h3, 32'h4, 32'h700, 32'h8);
        @(posedge soc_clk);
        #1;
        reset = 1'b1;
        @(posedge soc_clk);
        @(negedge soc_clk);
        chk("eval_rst_valid", 32'(res_valid), 32'd0);
        chk("eval_rst_taken", 32'(res_taken), 32'd0);
        chk("eval_rst_next_pc", res_next_pc, 32'd0);
        chk("eval_rst_alu_dat1", ALU_dat1, 32'd0);
        chk("eval_rst_alu_dat2", ALU_dat2, 32'd0);
        chk("eval_rst_br_ready", 32'(br_ready), 32'd0);
        @(posedge soc_clk);
        #1;
        reset = 1'b0;
        @(negedge soc_clk);
        chk("post_rst_br_ready", 32'(br_ready), 32'd1);

        // Long hold with a misaligned taken target
        do_branch(3'b001, 32'h1, 32'h2, 32'h300, 32'h6, 5);

        // Flush and res_ready together in HOLD: flush wins
        accept(3'b000, 32'h9, 32'h9, 32'h800, 32'h4);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge soc_clk);
            if (res_valid) begin
                seen = 1;
                break;
            end
        end
        chk("flush_hold_reached", 32'(seen), 32'd1);
        flush     = 1'b1;
        res_ready = 1'b1;
        @(posedge soc_clk);
        #1;
        flush     = 1'b0;
        res_ready = 1'b0;
        @(negedge soc_clk);
        chk("flush_hold_valid", 32'(res_valid), 32'd0);
        chk("flush_hold_taken", 32'(res_taken), 32'd0);
        chk("flush_hold_br_ready", 32'(br_ready), 32'd1);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
